// File: rtl/program_loader_pkg.sv
// Shared CPU-side definitions: loader FSM encoding, stream byte order, default memory depth.
package program_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 14;
  localparam bit          BIG_ENDIAN     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_FINISH
  } loader_state_e;

  // Shift one received byte into a partially assembled word.
  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return BIG_ENDIAN ? {word[23:0], b} : {b, word[31:8]};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader-facing bus: UART byte stream in, instruction-memory write port and status out.
interface program_loader_if import program_loader_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();
  logic              start_pg;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport slave (
    input  start_pg, rx_valid, rx_byte,
    output imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count
  );

  modport master (
    output start_pg, rx_valid, rx_byte,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs UART bytes into 32-bit words and tracks idle cycles between bytes.
module byte_assembler import program_loader_pkg::*; #(
  parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic        count_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o,
  output logic        timeout_o
);
  logic [31:0] shift_q;
  logic [1:0]  idx_q;
  logic [19:0] idle_q;

  // word_o already includes the byte being accepted, so the FSM can act on it this cycle.
  assign word_o      = shift_in(shift_q, byte_i);
  assign word_done_o = accept_i && (idx_q == 2'd3);
  assign timeout_o   = (idle_q >= TIMEOUT);

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      idle_q  <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      idle_q  <= '0;
    end else if (accept_i) begin
      shift_q <= word_o;
      idx_q   <= idx_q + 2'd1;
      idle_q  <= '0;
    end else if (count_en_i && (idle_q < TIMEOUT)) begin
      idle_q  <= idle_q + 20'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// UART program loader: reads a word-count header then writes N big-endian words to imem.
module program_loader import program_loader_pkg::*; #(
  parameter int          ADDR_W  = DEFAULT_ADDR_W,
  parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
  input  logic            clock,
  input  logic            reset,
  program_loader_if.slave bus
);
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  loader_state_e   state_q, state_d;
  logic [31:0]     n_q, n_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [ADDR_W:0] count_q, count_d, count_inc;
  logic            err_q, err_d;

  logic        accept, count_en, clear;
  logic [31:0] word;
  logic        word_done, timeout;

  assign accept   = bus.rx_valid && (state_q == ST_HDR || state_q == ST_DATA || state_q == ST_WRITE);
  assign count_en = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign clear    = (state_q == ST_IDLE) && bus.start_pg;
  assign count_inc = (&count_q) ? count_q : count_q + (ADDR_W+1)'(1);

  byte_assembler #(.TIMEOUT(TIMEOUT)) u_asm (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (clear),
    .accept_i    (accept),
    .count_en_i  (count_en),
    .byte_i      (bus.rx_byte),
    .word_o      (word),
    .word_done_o (word_done),
    .timeout_o   (timeout)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_pg) begin
          state_d = ST_HDR;
          err_d   = 1'b0;
          count_d = '0;
        end
      end
      ST_HDR: begin
        if (word_done) begin
          n_d = word;
          if (word == 32'd0) begin
            state_d = ST_FINISH;
          end else if ({1'b0, word} > MAX_WORDS) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else if (!bus.rx_valid && timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (word_done) begin
          wdata_d = word;
          state_d = ST_WRITE;
        end else if (!bus.rx_valid && timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WRITE: begin
        // A byte arriving now is absorbed by the assembler as byte 0 of the next word.
        count_d = count_inc;
        state_d = (32'(count_inc) == n_q) ? ST_FINISH : ST_DATA;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = count_q[ADDR_W-1:0];
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = (state_q != ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.err        = err_q;
  assign bus.word_count = count_q;
endmodule
